// File: rtl/vga_sync_decoder.sv
// Purpose: recovers pixel coordinates and timing lock from a sampled VGA h_sync/v_sync/blank_n stream.
// Latency: 2 clocks from an input pin transition to posx/posy/active/new_line/new_frame.
// Backpressure: none; a free-running pixel stream is consumed every clock. Option: VGA_DECODER_BLANK_CHECK_EN.
module vga_sync_decoder #(
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int H_DISP       = 640,
    parameter int H_FP         = 16,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int V_DISP       = 480,
    parameter int V_FP         = 10,
    parameter int BAD_LINE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic        blank_n,
    output logic [9:0]  posx,
    output logic [9:0]  posy,
    output logic        active,
    output logic        new_line,
    output logic        new_frame,
    output logic        locked,
    output logic [7:0]  err_cnt,
    output logic [15:0] blank_err_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HA_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA_END   = 10'(H_SYNC + H_BP + H_DISP);
    localparam logic [9:0] VA_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA_END   = 10'(V_SYNC + V_BP + V_DISP);
    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] CNT_PRE  = 10'd1022;
    localparam logic [7:0] RUN_LAST = 8'(BAD_LINE_MAX - 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     state, state_nxt;
    logic [7:0] bad_run, bad_run_nxt;
    logic       hs_q, hs_p, vs_q, vs_p;
    logic       h_edge, v_edge, v_pend, frame_start;
    logic [9:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic       sat_evt, line_bad, line_good, frame_bad, win_nxt;

    function automatic logic in_win(input logic [9:0] h, input logic [9:0] v);
        return (h >= HA_START) && (h < HA_END) && (v >= VA_START) && (v < VA_END);
    endfunction

    // Input sampling: current and previous sample; idle level 1 avoids a false edge at reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= 1'b1;
            hs_p <= 1'b1;
            vs_q <= 1'b1;
            vs_p <= 1'b1;
        end else begin
            hs_q <= h_sync;
            hs_p <= hs_q;
            vs_q <= v_sync;
            vs_p <= vs_q;
        end
    end

    // Edge detect, counter next values and line/frame timing checks
    always_comb begin
        h_edge      = hs_p & ~hs_q;
        v_edge      = vs_p & ~vs_q;
        frame_start = h_edge & (v_edge | v_pend);
        hcnt_nxt    = hcnt;
        vcnt_nxt    = vcnt;
        if (h_edge) begin
            hcnt_nxt = '0;
            if (v_edge || v_pend)
                vcnt_nxt = '0;
            else if (vcnt != CNT_MAX)
                vcnt_nxt = vcnt + 10'd1;
        end else if (hcnt != CNT_MAX) begin
            hcnt_nxt = hcnt + 10'd1;
        end
        // A saturated line is reported once on the way up; the edge that ends it is not re-checked
        sat_evt   = !h_edge && (hcnt == CNT_PRE);
        line_bad  = (h_edge && (hcnt != H_LAST) && (hcnt != CNT_MAX)) || sat_evt;
        line_good = h_edge && (hcnt == H_LAST);
        frame_bad = frame_start && (vcnt != V_LAST);
        win_nxt   = in_win(hcnt_nxt, vcnt_nxt);
    end

    // Line/frame counters and the pending v_sync edge awaiting the next h edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt   <= CNT_MAX;
            vcnt   <= CNT_MAX;
            v_pend <= 1'b0;
        end else begin
            hcnt   <= hcnt_nxt;
            vcnt   <= vcnt_nxt;
            v_pend <= h_edge ? 1'b0 : (v_pend | v_edge);
        end
    end

    // Lock FSM next state and consecutive bad-line run tracking
    always_comb begin
        state_nxt   = state;
        bad_run_nxt = bad_run;
        case (state)
            SEARCH: begin
                bad_run_nxt = '0;
                if (frame_start)
                    state_nxt = ALIGN;
            end
            ALIGN: begin
                bad_run_nxt = '0;
                if (line_bad || frame_bad)
                    state_nxt = SEARCH;
                else if (frame_start)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (line_bad) begin
                    if (bad_run == RUN_LAST) begin
                        state_nxt   = SEARCH;
                        bad_run_nxt = '0;
                    end else begin
                        bad_run_nxt = bad_run + 8'd1;
                    end
                end else if (line_good) begin
                    bad_run_nxt = '0;
                end
                if (frame_bad)
                    state_nxt = SEARCH;
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEARCH;
            bad_run <= '0;
        end else begin
            state   <= state_nxt;
            bad_run <= bad_run_nxt;
        end
    end

    // Saturating error count; a bad line and bad frame together count once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if ((state != SEARCH) && (line_bad || frame_bad) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'd1;
    end

    // Registered outputs, computed from next-state values to hold the 2-clock latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx      <= '0;
            posy      <= '0;
            active    <= 1'b0;
            new_line  <= 1'b0;
            new_frame <= 1'b0;
            locked    <= 1'b0;
        end else begin
            posx      <= win_nxt ? (hcnt_nxt - HA_START) : '0;
            posy      <= win_nxt ? (vcnt_nxt - VA_START) : '0;
            active    <= win_nxt && (state_nxt == LOCKED);
            new_line  <= h_edge;
            new_frame <= frame_start;
            locked    <= (state_nxt == LOCKED);
        end
    end

`ifdef VGA_DECODER_BLANK_CHECK_EN
    logic bn_q, bn_p, win_cur;

    assign win_cur = in_win(hcnt, vcnt);

    // blank_n delayed twice so it lines up with the current hcnt/vcnt window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bn_q <= 1'b1;
            bn_p <= 1'b1;
        end else begin
            bn_q <= blank_n;
            bn_p <= bn_q;
        end
    end

    // Count source blanking that disagrees with the recovered window while locked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blank_err_cnt <= '0;
        else if ((state == LOCKED) && (bn_p != win_cur) && (blank_err_cnt != 16'hFFFF))
            blank_err_cnt <= blank_err_cnt + 16'd1;
    end
`else
    logic unused_blank;
    assign unused_blank  = blank_n;
    assign blank_err_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
module tb_vga_sync_decoder;

    // Scaled-down timing so many frames fit in a short run: 28 clocks x 14 lines
    localparam int HS = 4, HB = 4, HD = 16, HF = 4;
    localparam int VS = 2, VB = 2, VD = 8, VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int HA0 = HS + HB, HA1 = HS + HB + HD;
    localparam int VA0 = VS + VB, VA1 = VS + VB + VD;
    localparam int PIX = HD * VD;
`ifdef VGA_DECODER_BLANK_CHECK_EN
    localparam int BLANK_EXP = 10;
`else
    localparam int BLANK_EXP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, h_sync, v_sync, blank_n;
    logic [9:0]  posx, posy;
    logic        active, new_line, new_frame, locked;
    logic [7:0]  err_cnt;
    logic [15:0] blank_err_cnt;

    int checks = 0;
    int errors = 0;
    int act_total = 0, nl_total = 0, nf_total = 0;
    bit seen_first = 1'b0;
    logic [9:0] first_x = '0, first_y = '0, last_x = '0, last_y = '0;
    logic        rst_locked;
    logic [7:0]  rst_err;
    logic [15:0] rst_blank;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BP(HB), .H_DISP(HD), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_DISP(VD), .V_FP(VF),
        .BAD_LINE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .blank_n(blank_n),
        .posx(posx), .posy(posy), .active(active), .new_line(new_line),
        .new_frame(new_frame), .locked(locked), .err_cnt(err_cnt),
        .blank_err_cnt(blank_err_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor: tallies active cycles and pulses, remembers first/last active position
    always @(posedge clk) begin
        #1;
        if (active) begin
            act_total++;
            if (!seen_first) begin
                first_x    = posx;
                first_y    = posy;
                seen_first = 1'b1;
            end
            last_x = posx;
            last_y = posy;
        end
        if (new_line)  nl_total++;
        if (new_frame) nf_total++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input bit kill);
        @(negedge clk);
        h_sync  = !(x < HS);
        v_sync  = !(y < VS);
        blank_n = (x >= HA0) && (x < HA1) && (y >= VA0) && (y < VA1) && !kill;
    endtask

    task automatic idle_pix(input int y);
        @(negedge clk);
        h_sync  = 1'b1;
        v_sync  = !(y < VS);
        blank_n = 1'b0;
    endtask

    // One generator frame with optional short lines, h_sync outage, blank glitch and mid-frame reset
    task automatic gen_frame(input int nlines, input int short_y, input int short_n,
                             input int pause_y, input int pause_len,
                             input int kill_y, input int rst_y);
        for (int y = 0; y < nlines; y++) begin
            int len;
            if (y == pause_y) repeat (pause_len) idle_pix(y);
            len = (y >= short_y && y < short_y + short_n) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                pix(x, y, (y == kill_y) && (x >= 10) && (x < 20));
                if (y == rst_y && x == 14) begin
                    rst_n = 1'b0;
                    #1;
                    rst_locked = locked;
                    rst_err    = err_cnt;
                    rst_blank  = blank_err_cnt;
                end
                if (y == rst_y && x == 15) rst_n = 1'b1;
            end
        end
    endtask

    task automatic clean_frame();
        gen_frame(VT, -1, 0, -1, 0, -1, -1);
    endtask

    initial begin
        int a0, n0, f0;
        rst_n = 1'b0; h_sync = 1'b1; v_sync = 1'b1; blank_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_posx", posx, 0);
        chk("rst_posy", posy, 0);
        chk("rst_active", active, 0);
        chk("rst_new_line", new_line, 0);
        chk("rst_new_frame", new_frame, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_blank_err", blank_err_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_locked", locked, 0);

        // First frame after the first v edge only aligns; lock comes at its end
        clean_frame();
        chk("f1_locked", locked, 0);
        a0 = act_total;
        clean_frame();
        chk("f2_locked", locked, 1);
        chk("f2_active", act_total - a0, PIX);
        a0 = act_total; n0 = nl_total; f0 = nf_total;
        clean_frame();
        chk("f3_active", act_total - a0, PIX);
        chk("f3_new_line", nl_total - n0, VT);
        chk("f3_new_frame", nf_total - f0, 1);
        chk("f3_err", err_cnt, 0);
        chk("first_posx", first_x, 0);
        chk("first_posy", first_y, 0);
        chk("last_posx", last_x, HD - 1);
        chk("last_posy", last_y, VD - 1);

        // One short line: counted, lock kept, next line realigned
        a0 = act_total;
        gen_frame(VT, 6, 1, -1, 0, -1, -1);
        chk("short1_err", err_cnt, 1);
        chk("short1_locked", locked, 1);
        chk("short1_active", act_total - a0, PIX);
        chk("short1_last_posx", last_x, HD - 1);

        // Four short lines: lock drops on the 4th bad edge
        a0 = act_total;
        gen_frame(VT, 6, 4, -1, 0, -1, -1);
        chk("short4_err", err_cnt, 5);
        chk("short4_locked", locked, 0);
        chk("short4_active", act_total - a0, 6 * HD);
        chk("short4_active_out", active, 0);
        clean_frame();
        chk("relock_align", locked, 0);
        a0 = act_total;
        clean_frame();
        chk("relock_locked", locked, 1);
        chk("relock_err", err_cnt, 5);
        chk("relock_active", act_total - a0, PIX);

        // Frame one line short: error on the next v edge, back to SEARCH
        a0 = act_total;
        gen_frame(VT - 1, -1, 0, -1, 0, -1, -1);
        chk("shortf_active", act_total - a0, PIX);
        chk("shortf_err_pre", err_cnt, 5);
        a0 = act_total;
        clean_frame();
        chk("shortf_err", err_cnt, 6);
        chk("shortf_locked", locked, 0);
        chk("shortf_active_none", act_total - a0, 0);
        clean_frame();
        chk("shortf_align", locked, 0);
        clean_frame();
        chk("shortf_relock", locked, 1);

        // h_sync missing for 1100 clocks: one error, lock survives
        a0 = act_total;
        gen_frame(VT, -1, 0, 5, 1100, -1, -1);
        chk("loss_err", err_cnt, 7);
        chk("loss_locked", locked, 1);
        chk("loss_active", act_total - a0, PIX);
        clean_frame();
        chk("loss_err_after", err_cnt, 7);
        chk("loss_locked_after", locked, 1);

        // blank_n forced low for 10 active clocks
        a0 = act_total;
        gen_frame(VT, -1, 0, -1, 0, 5, -1);
        chk("blank_err", blank_err_cnt, BLANK_EXP);
        chk("blank_active", act_total - a0, PIX);

        // Mid-frame reset clears immediately; relock takes align frame plus one
        gen_frame(VT, -1, 0, -1, 0, -1, 6);
        chk("mrst_async_locked", rst_locked, 0);
        chk("mrst_async_err", rst_err, 0);
        chk("mrst_async_blank", rst_blank, 0);
        chk("mrst_locked", locked, 0);
        chk("mrst_err", err_cnt, 0);
        clean_frame();
        chk("mrst_align", locked, 0);
        a0 = act_total;
        clean_frame();
        chk("mrst_relock", locked, 1);
        chk("mrst_err_final", err_cnt, 0);
        chk("mrst_active", act_total - a0, PIX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
